// File: rtl/mesh_term_agent.sv
// ---------------------------------------------------------------------------
// mesh_term_agent
//   Array of terminal agents, one per edge terminal of the mesh router.
//   Each terminal i has:
//     - a show-ahead inject FIFO that the mesh drains (TX side),
//     - a single-entry capture slot that pops packets out of the mesh (RX side),
//     - saturating tx/rx traffic counters,
//     - a destination-address check and sticky error flags.
//   Terminals are fully independent of each other.
//
// Ports (N = 2*ROWS + 2*COLUMS terminals, vectors packed terminal-major):
//   i_clk            clock, rising edge
//   i_reset          synchronous active-high reset
//   i_tx_push        [N]            host write strobe per inject FIFO
//   i_tx_data        [N*pckg_sz]    host packets
//   o_tx_full        [N]            inject FIFO holds fifo_depth entries
//   o_pndng_i_in     [N]            inject FIFO non-empty (to mesh)
//   o_data_out_i_in  [N*pckg_sz]    inject FIFO head (to mesh), 0 when empty
//   i_pop            [N]            mesh consumed the FIFO head
//   i_pndng          [N]            mesh has a packet for the terminal
//   i_data_out       [N*pckg_sz]    mesh packet for the terminal
//   o_popin          [N]            one-cycle pop pulse back to the mesh
//   o_rx_valid       [N]            capture slot full
//   o_rx_data        [N*pckg_sz]    captured packet
//   i_rx_ready       [N]            host consumes the capture slot
//   o_tx_cnt         [N*CNT_W]      packets taken by the mesh (saturating)
//   o_rx_cnt         [N*CNT_W]      packets captured (saturating)
//   o_err_addr       [N]            sticky: unicast packet with wrong destination
//   o_err_ovf        [N]            sticky: push while full or pop while empty
// ---------------------------------------------------------------------------
module mesh_term_agent #(
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter int         pckg_sz    = 32,
  parameter int         fifo_depth = 4,
  parameter logic [7:0] bdcst      = 8'hFF,
  parameter int         CNT_W      = 16,
  localparam int        N          = 2*ROWS + 2*COLUMS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N-1:0]         i_tx_push,
  input  logic [N*pckg_sz-1:0] i_tx_data,
  output logic [N-1:0]         o_tx_full,
  output logic [N-1:0]         o_pndng_i_in,
  output logic [N*pckg_sz-1:0] o_data_out_i_in,
  input  logic [N-1:0]         i_pop,
  input  logic [N-1:0]         i_pndng,
  input  logic [N*pckg_sz-1:0] i_data_out,
  output logic [N-1:0]         o_popin,
  output logic [N-1:0]         o_rx_valid,
  output logic [N*pckg_sz-1:0] o_rx_data,
  input  logic [N-1:0]         i_rx_ready,
  output logic [N*CNT_W-1:0]   o_tx_cnt,
  output logic [N*CNT_W-1:0]   o_rx_cnt,
  output logic [N-1:0]         o_err_addr,
  output logic [N-1:0]         o_err_ovf
);

  localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);

  typedef enum logic {ST_IDLE, ST_POP} rxState_t;

  for (genvar gi = 0; gi < N; gi++) begin : g_term

    // Fixed (row,col) of this terminal on the mesh perimeter: top edge,
    // left edge, bottom edge, then right edge.
    localparam int ROW_I = (gi < COLUMS)            ? 0 :
                           (gi < COLUMS + ROWS)     ? gi - COLUMS + 1 :
                           (gi < 2*COLUMS + ROWS)   ? ROWS + 1 :
                                                      gi - 2*COLUMS - ROWS + 1;
    localparam int COL_I = (gi < COLUMS)            ? gi + 1 :
                           (gi < COLUMS + ROWS)     ? 0 :
                           (gi < 2*COLUMS + ROWS)   ? gi - COLUMS - ROWS + 1 :
                                                      COLUMS + 1;
    localparam logic [3:0] MY_ROW = 4'(ROW_I);
    localparam logic [3:0] MY_COL = 4'(COL_I);

    // ---------------- TX inject FIFO ----------------
    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [AW-1:0]      r_rdPtr;
    logic [AW-1:0]      r_wrPtr;
    logic [CW-1:0]      r_count;
    logic               r_errOvf;
    logic [CNT_W-1:0]   r_txCnt;
    logic               w_full;
    logic               w_empty;
    logic               w_popOk;
    logic               w_pushOk;

    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_popOk  = i_pop[gi] & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_pushOk = i_tx_push[gi] & (~w_full | w_popOk);

    // Storage array carries no reset; stale contents are masked by the count.
    always_ff @(posedge i_clk) begin
      if (w_pushOk && !i_reset) begin
        r_mem[r_wrPtr] <= i_tx_data[gi*pckg_sz +: pckg_sz];
      end
    end

    // Pointers, occupancy, overflow flag and mesh-side traffic counter.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_rdPtr  <= '0;
        r_wrPtr  <= '0;
        r_count  <= '0;
        r_errOvf <= 1'b0;
        r_txCnt  <= '0;
      end else begin
        if (w_pushOk) begin
          r_wrPtr <= r_wrPtr + AW'(1);
        end
        if (w_popOk) begin
          r_rdPtr <= r_rdPtr + AW'(1);
          if (r_txCnt != '1) begin
            r_txCnt <= r_txCnt + CNT_W'(1);
          end
        end
        if (w_pushOk && !w_popOk) begin
          r_count <= r_count + CW'(1);
        end else if (w_popOk && !w_pushOk) begin
          r_count <= r_count - CW'(1);
        end
        if ((i_tx_push[gi] && w_full && !i_pop[gi]) || (i_pop[gi] && w_empty)) begin
          r_errOvf <= 1'b1;
        end
      end
    end

    assign o_tx_full[gi]                         = w_full;
    assign o_pndng_i_in[gi]                      = ~w_empty;
    assign o_data_out_i_in[gi*pckg_sz +: pckg_sz] = w_empty ? '0 : r_mem[r_rdPtr];
    assign o_err_ovf[gi]                         = r_errOvf;
    assign o_tx_cnt[gi*CNT_W +: CNT_W]           = r_txCnt;

    // ---------------- RX capture slot ----------------
    rxState_t           r_state;
    rxState_t           w_nextState;
    logic               w_capture;
    logic               w_popin;
    logic               r_rxValid;
    logic [pckg_sz-1:0] r_rxData;
    logic [CNT_W-1:0]   r_rxCnt;
    logic               r_errAddr;
    logic [pckg_sz-1:0] w_pkt;
    logic [7:0]         w_nxtJump;
    logic [3:0]         w_trgtRow;
    logic [3:0]         w_trgtCol;

    assign w_pkt     = i_data_out[gi*pckg_sz +: pckg_sz];
    assign w_nxtJump = w_pkt[pckg_sz-1 -: 8];
    assign w_trgtRow = w_pkt[pckg_sz-9 -: 4];
    assign w_trgtCol = w_pkt[pckg_sz-13 -: 4];

    // Capture only from IDLE; the POP cycle that follows hides pndng so the
    // mesh sees exactly one popin per packet.
    assign w_capture = (r_state == ST_IDLE) & i_pndng[gi] & (~r_rxValid | i_rx_ready[gi]);

    // State register for the capture handshake.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_nextState;
      end
    end

    // Next state and the popin pulse, which is high for the whole POP cycle.
    always_comb begin
      w_nextState = r_state;
      w_popin     = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            w_nextState = ST_POP;
          end
        end
        ST_POP: begin
          w_popin     = 1'b1;
          w_nextState = ST_IDLE;
        end
        default: w_nextState = ST_IDLE;
      endcase
    end

    // Capture slot contents, rx counter and sticky address error.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_rxValid <= 1'b0;
        r_rxData  <= '0;
        r_rxCnt   <= '0;
        r_errAddr <= 1'b0;
      end else if (w_capture) begin
        r_rxValid <= 1'b1;
        r_rxData  <= w_pkt;
        if (r_rxCnt != '1) begin
          r_rxCnt <= r_rxCnt + CNT_W'(1);
        end
        if ((w_nxtJump != bdcst) && ((w_trgtRow != MY_ROW) || (w_trgtCol != MY_COL))) begin
          r_errAddr <= 1'b1;
        end
      end else if (r_rxValid && i_rx_ready[gi]) begin
        r_rxValid <= 1'b0;
      end
    end

    assign o_popin[gi]                     = w_popin;
    assign o_rx_valid[gi]                  = r_rxValid;
    assign o_rx_data[gi*pckg_sz +: pckg_sz] = r_rxData;
    assign o_rx_cnt[gi*CNT_W +: CNT_W]     = r_rxCnt;
    assign o_err_addr[gi]                  = r_errAddr;
  end

endmodule
